// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin owner scheduler for a shared external 4:1 bit mux.
// Four requesters compete for the mux. The winner holds it for up to BURST_MAX
// cycles. The block drives the registered mux select, a one-hot grant, busy,
// and a handoff pulse on the first cycle of every new grant.
module mux4_rr_sched #(
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       handoff
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_OWN   = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    // Round-robin search starting just after 'base' and wrapping back to 'base'.
    // Returns {found, index}. The loop runs from the farthest candidate to the
    // nearest one, so the nearest requester that is asserted is what remains.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Decode a 2-bit index into a one-hot 4-bit vector.
    function automatic logic [3:0] onehot4(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    logic [0:0]       state_r, state_s;
    logic [1:0]       sel_r, sel_s;
    logic [3:0]       grant_r, grant_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       last_r, last_s;
    logic             handoff_r, handoff_s;
    logic             busy_r;

    logic             release_s;
    logic             may_grant_s;
    logic [1:0]       base_s;
    logic [2:0]       pick_s;

    // Release / arbitration-window decode for the current state.
    always_comb begin
        release_s   = 1'b0;
        may_grant_s = 1'b0;
        base_s      = last_r;
        case (state_r)
            ST_IDLE: begin
                release_s   = 1'b0;
                may_grant_s = 1'b1;
                base_s      = last_r;
            end
            ST_OWN: begin
                // Release when the owner drops its request or its burst has expired.
                release_s   = (req[sel_r] == 1'b0) || (cnt_r == CNT_LAST);
                may_grant_s = release_s;
                // On release the search starts after the owner, which also becomes 'last'.
                base_s      = sel_r;
            end
            default: begin
                release_s   = 1'b1;
                may_grant_s = 1'b0;
                base_s      = last_r;
            end
        endcase
        pick_s = rr_pick(req, base_s);
    end

    // Next-state computation: new grant, release to idle, or burst continuation.
    always_comb begin
        state_s   = state_r;
        sel_s     = sel_r;
        grant_s   = grant_r;
        cnt_s     = cnt_r;
        last_s    = last_r;
        handoff_s = 1'b0;

        if (release_s) begin
            last_s = sel_r;
        end else begin
            last_s = last_r;
        end

        if (may_grant_s && en && pick_s[2]) begin
            // Grant the winner immediately, even back-to-back after a release.
            state_s   = ST_OWN;
            sel_s     = pick_s[1:0];
            grant_s   = onehot4(pick_s[1:0]);
            cnt_s     = {CNT_W{1'b0}};
            handoff_s = 1'b1;
        end else if (release_s || (state_r != ST_OWN)) begin
            // Nobody to hand over to, or grants are blocked: idle. sel holds its value.
            state_s = ST_IDLE;
            grant_s = 4'b0000;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            // Burst continues.
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            sel_r     <= 2'b00;
            grant_r   <= 4'b0000;
            cnt_r     <= {CNT_W{1'b0}};
            last_r    <= 2'b11;
            handoff_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            sel_r     <= sel_s;
            grant_r   <= grant_s;
            cnt_r     <= cnt_s;
            last_r    <= last_s;
            handoff_r <= handoff_s;
            busy_r    <= |grant_s;
        end
    end

    assign sel     = sel_r;
    assign grant   = grant_r;
    assign busy    = busy_r;
    assign handoff = handoff_r;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Testbench for mux4_rr_sched: directed scenarios followed by random traffic.
// Every cycle is compared against a behavioural model of the scheduling rules.
module tb_mux4_rr_sched;

    localparam int BURST_MAX = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       handoff;

    int n_pass;
    int n_total;

    // Reference model state: owner index (-1 when idle) and cycles held so far.
    int m_owner;
    int m_held;
    int m_last;
    int m_sel;
    bit m_handoff;

    mux4_rr_sched #(.BURST_MAX(BURST_MAX), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .sel     (sel),
        .grant   (grant),
        .busy    (busy),
        .handoff (handoff)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the scheduling rules for one rising edge, using the sampled inputs.
    task automatic model_edge();
        bit released;
        released  = 1'b0;
        m_handoff = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 3;
            m_sel   = 0;
        end else begin
            if (m_owner >= 0) begin
                if (req[m_owner] == 1'b0 || m_held == BURST_MAX) begin
                    m_last   = m_owner;
                    m_owner  = -1;
                    released = 1'b1;
                end else begin
                    m_held = m_held + 1;
                end
            end
            if (m_owner < 0 && en && req != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % 4]) begin
                        m_owner = (m_last + k) % 4;
                    end
                end
                m_held    = 1;
                m_sel     = m_owner;
                m_handoff = 1'b1;
            end
            if (released && m_owner < 0) begin
                m_held = 0;
            end
        end
    endtask

    // Drive inputs, advance one clock edge, update the model, then compare.
    task automatic step(input logic r, input logic e, input logic [3:0] q);
        logic [3:0] exp_grant;
        rst = r;
        en  = e;
        req = q;
        @(posedge clk);
        model_edge();
        #1;
        exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check("grant",   8'(grant),   8'(exp_grant));
        check("sel",     8'(sel),     8'(m_sel));
        check("busy",    8'(busy),    8'(exp_grant != 4'b0000));
        check("handoff", 8'(handoff), 8'(m_handoff));
        check("onehot0", 8'($onehot0(grant)), 8'd1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_owner = -1;
        m_held  = 0;
        m_last  = 3;
        m_sel   = 0;
        m_handoff = 1'b0;
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;

        // Reset state.
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        check("rst_grant", 8'(grant), 8'h00);
        check("rst_sel",   8'(sel),   8'h00);

        // Single requester for three cycles, then idle.
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 1'b1, 4'b0001);
            check("single_grant",   8'(grant),   8'h01);
            check("single_handoff", 8'(handoff), (j == 0) ? 8'h01 : 8'h00);
        end
        step(1'b0, 1'b1, 4'b0000);
        check("single_idle", 8'(busy), 8'h00);
        step(1'b0, 1'b1, 4'b0000);

        // All requesting: rotation with BURST_MAX-cycle bursts and no gaps.
        step(1'b1, 1'b0, 4'b0000);
        for (int j = 0; j < 5 * BURST_MAX; j++) begin
            step(1'b0, 1'b1, 4'b1111);
            check("rot_grant",   8'(grant),   8'(4'b0001 << ((j / BURST_MAX) % 4)));
            check("rot_handoff", 8'(handoff), (j % BURST_MAX == 0) ? 8'h01 : 8'h00);
        end

        // Lone requester 2: re-granted each burst with a handoff pulse.
        step(1'b1, 1'b0, 4'b0000);
        for (int j = 0; j < 3 * BURST_MAX; j++) begin
            step(1'b0, 1'b1, 4'b0100);
            check("solo_grant",   8'(grant),   8'h04);
            check("solo_handoff", 8'(handoff), (j % BURST_MAX == 0) ? 8'h01 : 8'h00);
        end

        // Owner 1 drops its request in cycle 3 of its burst.
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b0010);
        step(1'b0, 1'b1, 4'b0110);
        step(1'b0, 1'b1, 4'b0110);
        check("own1_grant", 8'(grant), 8'h02);
        step(1'b0, 1'b1, 4'b0100);
        check("drop_grant",   8'(grant),   8'h04);
        check("drop_sel",     8'(sel),     8'h02);
        check("drop_handoff", 8'(handoff), 8'h01);

        // en low mid-burst: burst completes, then idle until en returns.
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b0011);
        for (int j = 1; j < BURST_MAX; j++) begin
            step(1'b0, 1'b0, 4'b0011);
            check("en0_hold", 8'(grant), 8'h01);
        end
        step(1'b0, 1'b0, 4'b0011);
        check("en0_idle", 8'(grant), 8'h00);
        step(1'b0, 1'b1, 4'b0011);
        check("en1_grant", 8'(grant), 8'h02);

        // Reset in cycle 5 of a burst by owner 3.
        step(1'b1, 1'b0, 4'b0000);
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 1'b1, 4'b1000);
        end
        check("own3_grant", 8'(grant), 8'h08);
        step(1'b1, 1'b1, 4'b1000);
        check("abort_grant", 8'(grant), 8'h00);
        check("abort_sel",   8'(sel),   8'h00);
        step(1'b0, 1'b1, 4'b1111);
        check("post_rst_grant", 8'(grant), 8'h01);

        // Random traffic: requests toggle rarely, en mostly high, occasional reset.
        for (int j = 0; j < 2000; j++) begin
            logic [3:0] q;
            q = req;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) q[b] = ~q[b];
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) != 0), q);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
